// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline hold / flush / redirect controller.
//
// Purpose:
//   Turns per-stage hold requests into a per-register stall vector. An
//   exception request is sequenced as follows:
//     - optionally wait in DRAIN until the outstanding memory transaction ends;
//     - issue a single FLUSH cycle that redirects the PC;
//     - run one quiet SETTLE cycle;
//     - return to IDLE.
//   If the drain takes too long, a timeout forces the flush and latches a
//   sticky error flag.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous, active-high reset
//   stallreq_if    in   IF stage hold request
//   stallreq_id    in   ID stage hold request
//   stallreq_ex    in   EX stage hold request
//   stallreq_dc    in   DC stage hold request
//   stallreq_mem   in   MEM stage hold request
//   mem_busy       in   data-memory transaction outstanding
//   excp_req       in   exception/redirect request (single-cycle pulse)
//   excp_pc        in   handler address, valid with excp_req
//   stall          out  per-register hold, 1=Stop
//                       bit0 PC, bit1 IF/ID, bit2 ID/EX-in, bit3 ID/EX,
//                       bit4 EX/DC, bit5 DC/MEM, bit6 MEM/WB
//   flush          out  clear all pipeline registers this cycle
//   new_pc         out  redirect target (holds last captured value)
//   redirect_valid out  PC loads new_pc this cycle
//   drain_tmo      out  sticky: a drain exceeded the timeout
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int STALL_W = 7,
   parameter int TMO_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_if,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               stallreq_dc,
   input  logic               stallreq_mem,
   input  logic               mem_busy,
   input  logic               excp_req,
   input  logic [31:0]        excp_pc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [31:0]        new_pc,
   output logic               redirect_valid,
   output logic               drain_tmo
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      FLUSH  = 2'd2,
      SETTLE = 2'd3
   } state_t;

   localparam logic [STALL_W-1:0] ALL_STOP = '1;
   localparam logic [TMO_W-1:0]   TMO_MAX  = '1;

   state_t              state_q;
   state_t              state_d;
   logic [TMO_W-1:0]    cnt_q;
   logic [31:0]         pc_q;
   logic                tmo_q;
   // High during the first cycle after reset is released; outputs stay quiet.
   logic                post_rst_q;
   logic [STALL_W-1:0]  req_stall;
   logic                hold;

   // Deepest requester wins. Every register up to and including the
   // requester's input register stops. The first NoStop register above the
   // stopped ones loads a bubble. A stage request never stops MEM/WB.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
      req_stall = '0;
      if (stallreq_mem)     req_stall = ALL_STOP >> (STALL_W - 6);
      else if (stallreq_dc) req_stall = ALL_STOP >> (STALL_W - 5);
      else if (stallreq_ex) req_stall = ALL_STOP >> (STALL_W - 4);
      else if (stallreq_id) req_stall = ALL_STOP >> (STALL_W - 3);
      else if (stallreq_if) req_stall = ALL_STOP >> (STALL_W - 2);
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (excp_req) state_d = mem_busy ? DRAIN : FLUSH;
         end
         DRAIN: begin
            // Leave when memory goes idle, or when the timeout has expired.
            if (!mem_busy || cnt_q == TMO_MAX) state_d = FLUSH;
         end
         FLUSH:   state_d = SETTLE;
         SETTLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic. Outputs are forced quiet while in reset and for one
   // cycle after reset, so an aborted redirect can never leak a flush pulse.
   assign hold = rst | post_rst_q;

   always_comb begin
      stall          = '0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      new_pc         = pc_q;
      case (state_q)
         IDLE:  stall = req_stall;
         DRAIN: stall = ALL_STOP;
         FLUSH: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
         end
         default: ;
      endcase
      if (hold) begin
         stall          = '0;
         flush          = 1'b0;
         redirect_valid = 1'b0;
         new_pc         = '0;
      end
   end

   assign drain_tmo = tmo_q;

   // State register, drain counter, captured PC and sticky timeout flag.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pc_q       <= '0;
         tmo_q      <= 1'b0;
         post_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         post_rst_q <= 1'b0;
         if (state_q == IDLE && excp_req) begin
            pc_q  <= excp_pc;
            cnt_q <= '0;
         end
         // Count busy DRAIN cycles, saturating at all-ones. The edge on
         // which the count reaches all-ones also raises the sticky flag.
         if (state_q == DRAIN && mem_busy && cnt_q != TMO_MAX) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == TMO_MAX - 1'b1) tmo_q <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STALL_W, default 7: width of the stall bus.
REQ-002 Parameter TMO_W, default 8: width of the drain-timeout counter.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 stallreq_if  input  1  IF stage requests a hold.
REQ-006 stallreq_id  input  1  ID stage requests a hold.
REQ-007 stallreq_ex  input  1  EX stage requests a hold.
REQ-008 stallreq_dc  input  1  DC stage requests a hold.
REQ-009 stallreq_mem  input  1  MEM stage requests a hold.
REQ-010 mem_busy  input  1  a data-memory transaction is outstanding.
REQ-011 excp_req  input  1  exception/redirect request, single-cycle pulse.
REQ-012 excp_pc  input  32  handler address, valid with excp_req.
REQ-013 stall  output  STALL_W  per-register hold: 1=Stop, 0=NoStop; bit0 PC, bit1 IF/ID, bit2 ID/EX-in, bit3 ID/EX, bit4 EX/DC, bit5 DC/MEM, bit6 MEM/WB.
REQ-014 flush  output  1  clear all pipeline registers this cycle.
REQ-015 new_pc  output  32  redirect target, valid when redirect_valid=1.
REQ-016 redirect_valid  output  1  PC shall load new_pc this cycle.
REQ-017 drain_tmo  output  1  sticky error: drain exceeded timeout.

Function
REQ-018 FSM states IDLE, DRAIN, FLUSH, SETTLE; reset state IDLE.
REQ-019 In IDLE, stall is combinational from requests, deepest requester wins: mem -> 7'h3F, dc -> 7'h1F, ex -> 7'h0F, id -> 7'h07, if -> 7'h03, none -> 7'h00.
REQ-020 The first NoStop bit above a Stop bit makes that boundary register load a bubble; pipe_ctrl never sets bit6 from a stage request.
REQ-021 IDLE and excp_req=1: excp_pc captured into a 32-bit register the same edge; next state DRAIN if mem_busy=1, else FLUSH.
REQ-022 excp_req in IDLE has priority over all stallreq inputs; stall in that cycle still follows REQ-019.
REQ-023 DRAIN: stall=7'h7F, flush=0; leaves to FLUSH on the first edge with mem_busy=0.
REQ-024 DRAIN: TMO_W-bit counter cleared on DRAIN entry, +1 per DRAIN cycle; reaching all-ones sets drain_tmo and forces FLUSH next edge; counter never wraps.
REQ-025 FLUSH: exactly one cycle; flush=1, redirect_valid=1, new_pc=captured excp_pc, stall=7'h00; next state SETTLE.
REQ-026 SETTLE: one cycle; stall=7'h00, flush=0, redirect_valid=0; all stallreq inputs ignored; next IDLE.
REQ-027 excp_req outside IDLE is dropped; captured excp_pc unchanged.
REQ-028 stallreq inputs ignored in DRAIN, FLUSH, SETTLE.
REQ-029 new_pc holds the last captured value when redirect_valid=0.
REQ-030 Latency excp_req to flush: 1 cycle with mem_busy=0; 1+N cycles with N busy cycles in DRAIN.

Reset
REQ-031 rst=1 at any edge: state IDLE, counter 0, captured pc 0, drain_tmo 0.
REQ-032 While in reset and first cycle after: stall=0, flush=0, redirect_valid=0, new_pc=0.
REQ-033 rst asserted mid-DRAIN or in FLUSH aborts the redirect; no flush pulse follows reset.
REQ-034 drain_tmo clears only on rst.

Verification
REQ-035 stallreq_ex=1 and stallreq_if=1, IDLE -> stall=7'h0F same cycle; release -> 7'h00.
REQ-036 excp_req=1, excp_pc=32'hBFC00380, mem_busy=0 -> next cycle flush=1, redirect_valid=1, new_pc=32'hBFC00380, stall=0; then SETTLE, IDLE.
REQ-037 excp_req with mem_busy=1 for 3 cycles -> stall=7'h7F for 3 cycles, flush on 4th cycle after request.
REQ-038 mem_busy stuck 1, TMO_W=8 -> after 255 DRAIN cycles drain_tmo=1, then flush pulse; drain_tmo stays 1.
REQ-039 second excp_req (pc 32'h80000000) during DRAIN -> ignored; flush carries first pc.
REQ-040 rst during DRAIN -> outputs zero, no flush pulse, stallreq_dc=1 after reset gives 7'h1F.
